seg_scan_capture: RTL and testbench

- Receive-side companion to the six-digit multiplexed 7-segment display driver.
- Samples the scanned common-node enables (active-low, one-cold), segment bus and decimal point, and rebuilds the 42-bit six-digit segment word and the 6-bit dp word.
- Flags digits that were dark during the last scan frame (blink/setting mode) and flags illegal enable patterns.
- Used for on-board self-test and as the bench monitor for the display path.

---
 rtl/seg_scan_capture.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive-side monitor for a six-digit multiplexed
// 7-segment display. Rebuilds the segment and decimal-point words from the
// scanned one-cold enables, reports digits left dark in the last frame,
// latches illegal enable patterns and flags a scan that has stopped.
module seg_scan_capture #(
   parameter int unsigned STABLE_CYCLES  = 4,      // 1..255
   parameter int unsigned TIMEOUT_CYCLES = 65535   // 16-bit
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  i_seg_enb,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   output logic [41:0] o_six_digit_seg,
   output logic [5:0]  o_six_dp,
   output logic [5:0]  o_dark,
   output logic        o_frame_done,
   output logic        o_enb_err,
   output logic        o_stall
);

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HELD
   } state_t;

   localparam logic [7:0]  STABLE_LIM  = 8'(STABLE_CYCLES);
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   // Input sample registers. Segment data is registered alongside the
   // enables so the captured data always belongs to the pattern being judged.
   logic [5:0]  enb_q, enb_prev_q;
   logic [6:0]  seg_q;
   logic        dp_q;

   // Dwell tracking
   state_t      state_q, state_d;
   logic [7:0]  stab_cnt_q, stab_cnt_d;

   // Frame reconstruction
   logic [5:0]  seen_q, seen_d;
   logic [2:0]  last_idx_q, last_idx_d;
   logic [41:0] seg_word_q, seg_word_d;
   logic [5:0]  dp_word_q, dp_word_d;
   logic [5:0]  dark_q, dark_d;
   logic        frame_done_q, frame_done_d;
   logic        enb_err_q, enb_err_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   // Pattern classification and decode
   logic [2:0]  zero_cnt;
   logic [2:0]  enb_idx;
   logic        is_legal, is_dark, is_illegal;
   logic        changed;
   logic [8:0]  stab_inc;
   logic        capture;
   logic        legal_cap;
   logic        frame_close;

   // Count the zero bits of the registered pattern and locate the selected digit.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      zero_cnt = '0;
      enb_idx  = '0;
      for (int k = 0; k < 6; k++) begin
         if (!enb_q[k]) begin
            zero_cnt = zero_cnt + 3'd1;
            enb_idx  = 3'(k);
         end
      end
   end

   assign is_legal   = (zero_cnt == 3'd1);
   assign is_dark    = &enb_q;
   assign is_illegal = !is_legal && !is_dark;
   assign changed    = (enb_q != enb_prev_q);
   assign stab_inc   = {1'b0, stab_cnt_q} + 9'd1;

   // Dwell FSM: a pattern is acted on once, after it has held STABLE_CYCLES.
   always_comb begin
      state_d    = state_q;
      stab_cnt_d = stab_cnt_q;
      capture    = 1'b0;
      unique case (state_q)
         ST_WAIT, ST_HELD: begin
            if (changed) begin
               state_d    = ST_SETTLE;
               stab_cnt_d = 8'd1;
            end
         end
         ST_SETTLE: begin
            if (changed) begin
               stab_cnt_d = 8'd1;
            end else if (stab_inc >= {1'b0, STABLE_LIM}) begin
               stab_cnt_d = STABLE_LIM;
               state_d    = ST_HELD;
               capture    = 1'b1;
            end else begin
               stab_cnt_d = stab_inc[7:0];
            end
         end
         default: begin
            state_d    = ST_WAIT;
            stab_cnt_d = '0;
         end
      endcase
   end

   // A legal capture at or below the previous digit index wraps the scan.
   // Last index resets to 0, so the first digit-0 capture after reset closes
   // an empty frame (all digits reported dark).
   assign legal_cap   = capture && is_legal;
   assign frame_close = legal_cap && (enb_idx <= last_idx_q);

   // Slot writes, seen mask, frame close, error latch and stall timer.
   always_comb begin
      seg_word_d   = seg_word_q;
      dp_word_d    = dp_word_q;
      seen_d       = seen_q;
      last_idx_d   = last_idx_q;
      dark_d       = dark_q;
      frame_done_d = 1'b0;
      enb_err_d    = enb_err_q;
      tmo_cnt_d    = tmo_cnt_q;

      if (legal_cap) begin
         for (int k = 0; k < 6; k++) begin
            if (enb_idx == 3'(k)) begin
               seg_word_d[7*k +: 7] = seg_q;
               dp_word_d[k]         = dp_q;
            end
         end
         last_idx_d = enb_idx;
         tmo_cnt_d  = '0;
         if (frame_close) begin
            dark_d       = ~seen_q;
            frame_done_d = 1'b1;
            seen_d       = 6'd1 << enb_idx;
         end else begin
            seen_d = seen_q | (6'd1 << enb_idx);
         end
      end else if (tmo_cnt_q != TIMEOUT_LIM) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end

      if (capture && is_illegal) begin
         enb_err_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register updates from the values present before the edge.
      if (rst) begin
         enb_q        <= 6'h3F;
         enb_prev_q   <= 6'h3F;
         seg_q        <= '0;
         dp_q         <= 1'b0;
         state_q      <= ST_WAIT;
         stab_cnt_q   <= '0;
         seen_q       <= '0;
         last_idx_q   <= '0;
         seg_word_q   <= '0;
         dp_word_q    <= '0;
         dark_q       <= 6'h3F;
         frame_done_q <= 1'b0;
         enb_err_q    <= 1'b0;
         tmo_cnt_q    <= '0;
      end else begin
         enb_q        <= i_seg_enb;
         enb_prev_q   <= enb_q;
         seg_q        <= i_seg;
         dp_q         <= i_seg_dp;
         state_q      <= state_d;
         stab_cnt_q   <= stab_cnt_d;
         seen_q       <= seen_d;
         last_idx_q   <= last_idx_d;
         seg_word_q   <= seg_word_d;
         dp_word_q    <= dp_word_d;
         dark_q       <= dark_d;
         frame_done_q <= frame_done_d;
         enb_err_q    <= enb_err_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign o_six_digit_seg = seg_word_q;
   assign o_six_dp        = dp_word_q;
   assign o_dark          = dark_q;
   assign o_frame_done    = frame_done_q;
   assign o_enb_err       = enb_err_q;
   assign o_stall         = (tmo_cnt_q == TIMEOUT_LIM);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Testbench for seg_scan_capture: a reference model predicts every frame
// close and queues the expected dark/segment/dp words; a monitor pops and
// compares them on each o_frame_done pulse. Scenario tasks add direct checks.
module tb_seg_scan_capture;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic [5:0]  dark;
      logic [41:0] seg;
      logic [5:0]  dp;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  i_seg_enb;
   logic [6:0]  i_seg;
   logic        i_seg_dp;
   logic [41:0] o_six_digit_seg;
   logic [5:0]  o_six_dp;
   logic [5:0]  o_dark;
   logic        o_frame_done;
   logic        o_enb_err;
   logic        o_stall;

   int errors = 0;
   int checks = 0;

   frame_t      exp_q[$];
   frame_t      mon_exp;
   logic [41:0] m_seg;
   logic [5:0]  m_dp;
   logic [5:0]  m_seen;
   int          m_last;
   logic        m_err;
   logic        fd_prev = 1'b0;
   logic [6:0]  segs [6];

   always #5 clk = ~clk;

   seg_scan_capture #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_seg_enb      (i_seg_enb),
      .i_seg          (i_seg),
      .i_seg_dp       (i_seg_dp),
      .o_six_digit_seg(o_six_digit_seg),
      .o_six_dp       (o_six_dp),
      .o_dark         (o_dark),
      .o_frame_done   (o_frame_done),
      .o_enb_err      (o_enb_err),
      .o_stall        (o_stall)
   );

   // Frame-close monitor: each pulse must match the oldest predicted frame.
   always @(negedge clk) begin
      if (rst) begin
         fd_prev = 1'b0;
      end else begin
         if (o_frame_done) begin
            checks++;
            if (fd_prev) begin
               errors++;
               $display("FAIL frame_done_width: got high two cycles in a row, expected single-cycle pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_done_unexpected: got pulse at %0t, expected none", $time);
            end else begin
               mon_exp = exp_q.pop_front();
               checks++;
               if (o_dark !== mon_exp.dark) begin
                  errors++;
                  $display("FAIL frame_dark: got %b expected %b", o_dark, mon_exp.dark);
               end
               checks++;
               if (o_six_digit_seg !== mon_exp.seg) begin
                  errors++;
                  $display("FAIL frame_seg: got %h expected %h", o_six_digit_seg, mon_exp.seg);
               end
               checks++;
               if (o_six_dp !== mon_exp.dp) begin
                  errors++;
                  $display("FAIL frame_dp: got %b expected %b", o_six_dp, mon_exp.dp);
               end
            end
         end
         fd_prev = o_frame_done;
      end
   end

   task automatic model_reset();
      m_seg  = '0;
      m_dp   = '0;
      m_seen = '0;
      m_last = 0;
      m_err  = 1'b0;
      exp_q.delete();
   endtask

   // Legal capture of digit k; a wrap pushes the frame the DUT must report.
   task automatic model_capture(input int k, input logic [6:0] s, input logic d);
      frame_t f;
      logic   close;
      close          = (k <= m_last);
      f.dark         = ~m_seen;
      m_seg[7*k +: 7] = s;
      m_dp[k]        = d;
      if (close) begin
         f.seg  = m_seg;
         f.dp   = m_dp;
         exp_q.push_back(f);
         m_seen = 6'd1 << k;
      end else begin
         m_seen[k] = 1'b1;
      end
      m_last = k;
   endtask

   // Hold one enable pattern for len cycles; the model predicts its effect.
   task automatic dwell(input logic [5:0] enb, input logic [6:0] s, input logic d, input int len);
      int zeros;
      int idx;
      zeros = 0;
      idx   = 0;
      i_seg_enb = enb;
      i_seg     = s;
      i_seg_dp  = d;
      for (int k = 0; k < 6; k++) begin
         if (!enb[k]) begin
            zeros++;
            idx = k;
         end
      end
      if (len >= STABLE) begin
         if (zeros == 1) model_capture(idx, s, d);
         else if (zeros >= 2) m_err = 1'b1;
      end
      repeat (len) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_drained(input string name);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending_frames: got %0d outstanding expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      i_seg_enb = 6'h3F;
      i_seg     = '0;
      i_seg_dp  = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (o_six_digit_seg !== 42'd0) begin
         errors++;
         $display("FAIL reset_seg: got %h expected 0", o_six_digit_seg);
      end
      checks++;
      if (o_six_dp !== 6'd0) begin
         errors++;
         $display("FAIL reset_dp: got %b expected 000000", o_six_dp);
      end
      checks++;
      if (o_dark !== 6'b111111) begin
         errors++;
         $display("FAIL reset_dark: got %b expected 111111", o_dark);
      end
      checks++;
      if (o_frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_frame_done: got %b expected 0", o_frame_done);
      end
      checks++;
      if (o_enb_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_enb_err: got %b expected 0", o_enb_err);
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b expected 0", o_stall);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_normal_scan();
      segs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 6; k++) begin
            dwell(~(6'd1 << k), segs[k], (k == 0), 10);
         end
      end
      dwell(6'b111110, segs[0], 1'b1, 10);
      check_drained("normal");
      checks++;
      if (o_six_digit_seg !== {7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}) begin
         errors++;
         $display("FAIL normal_seg: got %h expected %h", o_six_digit_seg,
                  {7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F});
      end
      checks++;
      if (o_six_dp !== 6'b000001) begin
         errors++;
         $display("FAIL normal_dp: got %b expected 000001", o_six_dp);
      end
      checks++;
      if (o_dark !== 6'b000000) begin
         errors++;
         $display("FAIL normal_dark: got %b expected 000000", o_dark);
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++;
         $display("FAIL normal_stall: got %b expected 0", o_stall);
      end
   endtask

   task automatic test_glitch();
      dwell(6'b011111, 7'h6D, 1'b0, 10);
      dwell(6'b111110, 7'h3F, 1'b1, 10);
      dwell(6'b111101, 7'h7F, 1'b1, 3);
      dwell(6'b111110, 7'h3F, 1'b1, 10);
      check_drained("glitch");
      checks++;
      if (o_six_digit_seg[13:7] !== 7'h06) begin
         errors++;
         $display("FAIL glitch_slot1: got %h expected 06", o_six_digit_seg[13:7]);
      end
      checks++;
      if (o_six_dp[1] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_dp1: got %b expected 0", o_six_dp[1]);
      end
      checks++;
      if (o_dark !== 6'b111110) begin
         errors++;
         $display("FAIL glitch_dark: got %b expected 111110", o_dark);
      end
   endtask

   task automatic test_blink();
      for (int k = 1; k < 6; k++) dwell(~(6'd1 << k), 7'(8'h10 + k), 1'b0, 10);
      dwell(6'b111111, 7'h00, 1'b0, 20);
      for (int k = 2; k < 6; k++) dwell(~(6'd1 << k), 7'(8'h20 + k), 1'b0, 10);
      checks++;
      if (o_six_digit_seg[13:0] !== {7'h11, 7'h3F}) begin
         errors++;
         $display("FAIL blink_kept_slots: got %h expected %h", o_six_digit_seg[13:0], {7'h11, 7'h3F});
      end
      dwell(6'b111110, 7'h3F, 1'b1, 10);
      check_drained("blink");
      checks++;
      if (o_dark !== 6'b000011) begin
         errors++;
         $display("FAIL blink_dark: got %b expected 000011", o_dark);
      end
      checks++;
      if (o_six_digit_seg[13:7] !== 7'h11) begin
         errors++;
         $display("FAIL blink_slot1: got %h expected 11", o_six_digit_seg[13:7]);
      end
   endtask

   task automatic test_illegal();
      dwell(6'b111100, 7'h7F, 1'b1, 3);
      dwell(6'b111101, 7'h31, 1'b0, 10);
      checks++;
      if (o_enb_err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_short: got %b expected 0", o_enb_err);
      end
      dwell(6'b110011, 7'h7F, 1'b1, 4);
      dwell(6'b111011, 7'h32, 1'b0, 10);
      checks++;
      if (o_enb_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_set: got %b expected 1", o_enb_err);
      end
      for (int k = 3; k < 6; k++) dwell(~(6'd1 << k), 7'(8'h30 + k), 1'b0, 10);
      dwell(6'b111110, 7'h3F, 1'b1, 10);
      check_drained("illegal");
      checks++;
      if (o_enb_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_sticky: got %b expected 1", o_enb_err);
      end
      checks++;
      if (o_six_digit_seg[20:14] !== 7'h32) begin
         errors++;
         $display("FAIL illegal_slot2: got %h expected 32", o_six_digit_seg[20:14]);
      end
      checks++;
      if (o_six_digit_seg !== m_seg) begin
         errors++;
         $display("FAIL illegal_word: got %h expected %h", o_six_digit_seg, m_seg);
      end
   endtask

   task automatic test_reset_mid_frame();
      dwell(6'b111101, 7'h41, 1'b0, 10);
      dwell(6'b111011, 7'h42, 1'b1, 10);
      check_drained("pre_reset");
      test_reset();
      dwell(6'b111110, 7'h50, 1'b0, 10);
      for (int k = 3; k < 6; k++) dwell(~(6'd1 << k), 7'(8'h50 + k), 1'b0, 10);
      dwell(6'b111110, 7'h50, 1'b0, 10);
      check_drained("post_reset");
      checks++;
      if (o_dark !== 6'b000110) begin
         errors++;
         $display("FAIL reset_mid_dark: got %b expected 000110", o_dark);
      end
      checks++;
      if (o_six_digit_seg[20:7] !== 14'd0) begin
         errors++;
         $display("FAIL reset_mid_slots12: got %h expected 0", o_six_digit_seg[20:7]);
      end
      checks++;
      if (o_enb_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_err: got %b expected 0", o_enb_err);
      end
   endtask

   task automatic test_stall();
      test_reset();
      repeat (TIMEOUT - 1) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (o_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_early: got %b expected 0", o_stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_rise: got %b expected 1", o_stall);
      end
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (o_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: got %b expected 1", o_stall);
      end
      i_seg_enb = 6'b111110;
      i_seg     = 7'h3F;
      i_seg_dp  = 1'b0;
      model_capture(0, 7'h3F, 1'b0);
      repeat (STABLE) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (o_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_before_capture: got %b expected 1", o_stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_clear: got %b expected 0", o_stall);
      end
      check_drained("stall");
   endtask

   initial begin
      test_reset();
      test_normal_scan();
      test_glitch();
      test_blink();
      test_illegal();
      test_reset_mid_frame();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
